// File: rtl/trig_lock_monitor.sv
// Per-VFAT phase-lock qualifier: lock FSM, saturating error counters and S-bit gating
// between trig_alignment and clustering.
module trig_lock_monitor #(
  parameter int DDR           = 0,
  parameter int LOCK_CYCLES   = 1024,
  parameter int ERR_CNT_WIDTH = 12
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [1536+1536*DDR-1:0]        sbits_i,
  input  logic [191:0]                    phase_err,
  input  logic [23:0]                     vfat_mask,
  input  logic                            cnt_reset,
  output logic [1536+1536*DDR-1:0]        sbits_o,
  output logic [23:0]                     vfat_locked,
  output logic [23:0]                     lost_lock,
  output logic [24*ERR_CNT_WIDTH-1:0]     err_cnt,
  output logic                            all_locked
);

  // state       | meaning
  // ST_UNLOCKED | counting consecutive clean clocks toward lock; S-bits dropped
  // ST_LOCKED   | clean lock window completed; S-bits passed until next phase error

  localparam int SW = 64 * (1 + DDR);
  localparam int NB = 24 * SW;
  localparam int GW = $clog2(LOCK_CYCLES);
  localparam logic [GW-1:0]            GOOD_MAX = GW'(LOCK_CYCLES - 1);
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX  = '1;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;

  lock_state_t              r_state [24];
  lock_state_t              w_state_next [24];
  logic [GW-1:0]            r_good [24];
  logic [GW-1:0]            w_good_next [24];
  logic [ERR_CNT_WIDTH-1:0] r_err [24];
  logic [23:0]              w_verr;
  logic [23:0]              w_lock_next;
  logic [23:0]              w_lost_set;
  logic [23:0]              r_lost;
  logic [NB-1:0]            w_qual;
  logic [NB-1:0]            r_sbits;
  logic                     r_all;

  always_comb begin
    for (int v = 0; v < 24; v++) begin
      w_verr[v]       = |phase_err[v*8 +: 8];
      w_state_next[v] = r_state[v];
      w_good_next[v]  = r_good[v];
      w_lost_set[v]   = 1'b0;
      case (r_state[v])
        ST_UNLOCKED: begin
          if (w_verr[v]) begin
            w_good_next[v] = '0;
          end else if (r_good[v] == GOOD_MAX) begin
            w_state_next[v] = ST_LOCKED;
            w_good_next[v]  = '0;
          end else begin
            w_good_next[v] = r_good[v] + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (w_verr[v]) begin
            w_state_next[v] = ST_UNLOCKED;
            w_good_next[v]  = '0;
            w_lost_set[v]   = 1'b1;
          end
        end
        default: begin
          w_state_next[v] = ST_UNLOCKED;
          w_good_next[v]  = '0;
        end
      endcase
    end
  end

  // Gate with the next state so the errored BX itself is dropped and the
  // BX that completes the lock window is passed.
  always_comb begin
    w_lock_next = '0;
    w_qual      = '0;
    for (int v = 0; v < 24; v++) begin
      w_lock_next[v]      = (w_state_next[v] == ST_LOCKED);
      w_qual[v*SW +: SW]  = {SW{w_lock_next[v] & ~vfat_mask[v]}};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int v = 0; v < 24; v++) begin
        r_state[v] <= ST_UNLOCKED;
        r_good[v]  <= '0;
        r_err[v]   <= '0;
      end
      r_lost  <= '0;
      r_sbits <= '0;
      r_all   <= 1'b0;
    end else begin
      for (int v = 0; v < 24; v++) begin
        r_state[v] <= w_state_next[v];
        r_good[v]  <= w_good_next[v];
        if (cnt_reset)
          r_err[v] <= '0;
        else if (w_verr[v] && (r_err[v] != CNT_MAX))
          r_err[v] <= r_err[v] + 1'b1;
      end
      r_lost  <= cnt_reset ? '0 : (r_lost | w_lost_set);
      r_sbits <= sbits_i & w_qual;
      r_all   <= &(w_lock_next | vfat_mask);
    end
  end

  always_comb begin
    vfat_locked = '0;
    err_cnt     = '0;
    for (int v = 0; v < 24; v++) begin
      vfat_locked[v]                             = (r_state[v] == ST_LOCKED);
      err_cnt[v*ERR_CNT_WIDTH +: ERR_CNT_WIDTH]  = r_err[v];
    end
  end

  assign lost_lock  = r_lost;
  assign sbits_o    = r_sbits;
  assign all_locked = r_all;

endmodule

// File: tb/tb_trig_lock_monitor.sv
// Directed bench for trig_lock_monitor: an SDR instance (4-bit counters) and a DDR
// instance (12-bit counters) share the same control stimulus.
module tb_trig_lock_monitor;

  logic          clock = 1'b0;
  logic          reset;
  logic [1535:0] s_sbits_i;
  logic [3071:0] d_sbits_i;
  logic [191:0]  phase_err;
  logic [23:0]   vfat_mask;
  logic          cnt_reset;

  logic [1535:0] s_sbits_o;
  logic [23:0]   s_locked, s_lost;
  logic [95:0]   s_err;
  logic          s_all;
  logic [3071:0] d_sbits_o;
  logic [23:0]   d_locked, d_lost;
  logic [287:0]  d_err;
  logic          d_all;

  int checks = 0;
  int errors = 0;

  logic [1535:0] s_exp;
  logic [3071:0] d_exp;
  logic [63:0]   pat64;

  always #5 clock = ~clock;

  trig_lock_monitor #(.DDR(0), .LOCK_CYCLES(16), .ERR_CNT_WIDTH(4)) u_sdr (
    .clock(clock), .reset(reset), .sbits_i(s_sbits_i), .phase_err(phase_err),
    .vfat_mask(vfat_mask), .cnt_reset(cnt_reset), .sbits_o(s_sbits_o),
    .vfat_locked(s_locked), .lost_lock(s_lost), .err_cnt(s_err), .all_locked(s_all));

  trig_lock_monitor #(.DDR(1), .LOCK_CYCLES(16), .ERR_CNT_WIDTH(12)) u_ddr (
    .clock(clock), .reset(reset), .sbits_i(d_sbits_i), .phase_err(phase_err),
    .vfat_mask(vfat_mask), .cnt_reset(cnt_reset), .sbits_o(d_sbits_o),
    .vfat_locked(d_locked), .lost_lock(d_lost), .err_cnt(d_err), .all_locked(d_all));

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; cnt_reset = 1'b0; phase_err = '0; vfat_mask = '0;
    s_sbits_i = '1; d_sbits_i = '1;
    tick(2);
    checks++; if (s_locked !== 24'h0) begin errors++; $display("FAIL rst_s_locked got %h exp 0", s_locked); end
    checks++; if (s_sbits_o !== '0) begin errors++; $display("FAIL rst_s_sbits got ones=%0d exp ones=0", $countones(s_sbits_o)); end
    checks++; if (s_lost !== 24'h0 || s_err !== 96'h0 || s_all !== 1'b0) begin errors++; $display("FAIL rst_s_status got lost=%h err=%h all=%b exp 0", s_lost, s_err, s_all); end
    checks++; if (d_locked !== 24'h0 || d_sbits_o !== '0 || d_all !== 1'b0) begin errors++; $display("FAIL rst_d_status got locked=%h all=%b ones=%0d exp 0", d_locked, d_all, $countones(d_sbits_o)); end
  endtask

  task automatic test_clean_lock;
    reset = 1'b0;
    tick(15);
    checks++; if (s_locked !== 24'h0 || s_sbits_o !== '0) begin errors++; $display("FAIL lock15_s got locked=%h ones=%0d exp 0", s_locked, $countones(s_sbits_o)); end
    checks++; if (d_locked !== 24'h0 || d_sbits_o !== '0) begin errors++; $display("FAIL lock15_d got locked=%h ones=%0d exp 0", d_locked, $countones(d_sbits_o)); end
    tick(1);
    checks++; if (s_locked !== 24'hFFFFFF || s_all !== 1'b1) begin errors++; $display("FAIL lock16_s got locked=%h all=%b exp ffffff 1", s_locked, s_all); end
    checks++; if (s_sbits_o !== {1536{1'b1}}) begin errors++; $display("FAIL lock16_s_sbits got ones=%0d exp ones=1536", $countones(s_sbits_o)); end
    checks++; if (d_locked !== 24'hFFFFFF || d_sbits_o !== {3072{1'b1}}) begin errors++; $display("FAIL lock16_d got locked=%h ones=%0d exp ffffff 3072", d_locked, $countones(d_sbits_o)); end
  endtask

  task automatic test_glitch;
    phase_err[13] = 1'b1;
    tick(1);
    phase_err = '0;
    s_exp = '1; s_exp[127:64] = '0;
    d_exp = '1; d_exp[255:128] = '0;
    checks++; if (s_locked !== 24'hFFFFFD || s_lost !== 24'h000002) begin errors++; $display("FAIL glitch_s_lock got locked=%h lost=%h exp fffffd 000002", s_locked, s_lost); end
    checks++; if (s_sbits_o !== s_exp) begin errors++; $display("FAIL glitch_s_sbits got ones=%0d slice1=%h exp ones=1472 slice1=0", $countones(s_sbits_o), s_sbits_o[127:64]); end
    checks++; if (s_err !== 96'h10) begin errors++; $display("FAIL glitch_s_err got %h exp 10", s_err); end
    checks++; if (d_sbits_o !== d_exp || d_lost !== 24'h000002) begin errors++; $display("FAIL glitch_d got ones=%0d lost=%h exp ones=2944 lost=000002", $countones(d_sbits_o), d_lost); end
    checks++; if (d_err !== (288'h1 << 12)) begin errors++; $display("FAIL glitch_d_err got %h exp 1000", d_err); end
    tick(15);
    checks++; if (s_sbits_o !== s_exp || s_locked[1] !== 1'b0) begin errors++; $display("FAIL glitch15_s got ones=%0d lk1=%b exp ones=1472 lk1=0", $countones(s_sbits_o), s_locked[1]); end
    checks++; if (d_sbits_o !== d_exp) begin errors++; $display("FAIL glitch15_d got ones=%0d exp ones=2944", $countones(d_sbits_o)); end
    tick(1);
    checks++; if (s_locked !== 24'hFFFFFF || s_sbits_o !== {1536{1'b1}}) begin errors++; $display("FAIL relock_s got locked=%h ones=%0d exp ffffff 1536", s_locked, $countones(s_sbits_o)); end
    checks++; if (d_locked !== 24'hFFFFFF || d_sbits_o !== {3072{1'b1}}) begin errors++; $display("FAIL relock_d got locked=%h ones=%0d exp ffffff 3072", d_locked, $countones(d_sbits_o)); end
  endtask

  task automatic test_mask;
    pat64 = 64'h0123456789ABCDEF;
    s_sbits_i = {24{pat64}};
    d_sbits_i = {48{pat64}};
    vfat_mask = 24'h800001;
    tick(1);
    s_exp = {24{pat64}}; s_exp[63:0] = '0; s_exp[1535:1472] = '0;
    d_exp = {48{pat64}}; d_exp[127:0] = '0; d_exp[3071:2944] = '0;
    checks++; if (s_sbits_o !== s_exp) begin errors++; $display("FAIL mask_s_sbits got lo=%h hi=%h mid=%h exp lo=0 hi=0 mid=%h", s_sbits_o[63:0], s_sbits_o[1535:1472], s_sbits_o[127:64], pat64); end
    checks++; if (d_sbits_o !== d_exp) begin errors++; $display("FAIL mask_d_sbits got lo=%h hi=%h exp 0 0", d_sbits_o[127:0], d_sbits_o[3071:2944]); end
    checks++; if (s_all !== 1'b1 || d_all !== 1'b1) begin errors++; $display("FAIL mask_all got s=%b d=%b exp 1 1", s_all, d_all); end
    phase_err[2] = 1'b1;
    tick(1);
    phase_err = '0;
    checks++; if (s_locked !== 24'hFFFFFE || s_all !== 1'b1) begin errors++; $display("FAIL mask_err_s got locked=%h all=%b exp fffffe 1", s_locked, s_all); end
    checks++; if (s_err !== 96'h11 || s_lost !== 24'h000003) begin errors++; $display("FAIL mask_err_cnt got err=%h lost=%h exp 11 000003", s_err, s_lost); end
    vfat_mask = '0;
    tick(1);
    s_exp = {24{pat64}}; s_exp[63:0] = '0;
    checks++; if (s_all !== 1'b0 || d_all !== 1'b0) begin errors++; $display("FAIL unmask_all got s=%b d=%b exp 0 0", s_all, d_all); end
    checks++; if (s_sbits_o !== s_exp) begin errors++; $display("FAIL unmask_s_sbits got lo=%h hi=%h exp lo=0 hi=%h", s_sbits_o[63:0], s_sbits_o[1535:1472], pat64); end
  endtask

  task automatic test_saturation;
    cnt_reset = 1'b1;
    tick(1);
    cnt_reset = 1'b0;
    checks++; if (s_err !== 96'h0 || s_lost !== 24'h0 || d_err !== 288'h0) begin errors++; $display("FAIL clear got s_err=%h lost=%h exp 0", s_err, s_lost); end
    phase_err[0] = 1'b1;
    tick(40);
    checks++; if (s_err !== 96'hF) begin errors++; $display("FAIL sat_s_err got %h exp f", s_err); end
    checks++; if (d_err !== 288'd40) begin errors++; $display("FAIL sat_d_err got %h exp 28", d_err); end
    phase_err = '0;
    tick(16);
    checks++; if (s_locked !== 24'hFFFFFF || s_err !== 96'hF) begin errors++; $display("FAIL sat_relock got locked=%h err=%h exp ffffff f", s_locked, s_err); end
    cnt_reset = 1'b1; phase_err[0] = 1'b1;
    tick(1);
    cnt_reset = 1'b0; phase_err = '0;
    checks++; if (s_err !== 96'h0 || s_lost !== 24'h0 || s_locked !== 24'hFFFFFE) begin errors++; $display("FAIL clear_wins_s got err=%h lost=%h locked=%h exp 0 0 fffffe", s_err, s_lost, s_locked); end
    checks++; if (d_err !== 288'h0 || d_lost !== 24'h0) begin errors++; $display("FAIL clear_wins_d got err=%h lost=%h exp 0 0", d_err, d_lost); end
  endtask

  task automatic test_reset_mid;
    reset = 1'b1;
    tick(1);
    checks++; if (s_locked !== 24'h0 || s_sbits_o !== '0 || s_all !== 1'b0 || s_err !== 96'h0 || s_lost !== 24'h0) begin errors++; $display("FAIL mid_rst_s got locked=%h all=%b ones=%0d exp 0", s_locked, s_all, $countones(s_sbits_o)); end
    reset = 1'b0;
    tick(10);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++; if (s_locked !== 24'h0 || d_locked !== 24'h0 || s_sbits_o !== '0) begin errors++; $display("FAIL mid_rst2 got s=%h d=%h exp 0", s_locked, d_locked); end
    tick(6);
    checks++; if (s_locked !== 24'h0 || d_locked !== 24'h0) begin errors++; $display("FAIL mid_6th got s=%h d=%h exp 0", s_locked, d_locked); end
    tick(9);
    checks++; if (s_locked !== 24'h0 || s_sbits_o !== '0) begin errors++; $display("FAIL mid_15th got locked=%h ones=%0d exp 0", s_locked, $countones(s_sbits_o)); end
    tick(1);
    checks++; if (s_locked !== 24'hFFFFFF || s_sbits_o !== {24{pat64}} || s_all !== 1'b1) begin errors++; $display("FAIL mid_16th got locked=%h all=%b exp ffffff 1", s_locked, s_all); end
    checks++; if (d_locked !== 24'hFFFFFF || d_sbits_o !== {48{pat64}}) begin errors++; $display("FAIL mid_16th_d got locked=%h exp ffffff", d_locked); end
  endtask

  initial begin
    test_reset;
    test_clean_lock;
    test_glitch;
    test_mask;
    test_saturation;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trig_lock_monitor.md
# trig_lock_monitor

Per-VFAT phase-lock qualifier that sits directly downstream of `trig_alignment` in the trigger path. It consumes the 40 MHz deserialized S-bit bus and the per-pin `phase_err` flags produced by the aligner. For each of the 24 VFATs it runs a lock state machine, keeps saturating error counters, and zeroes S-bits from any VFAT that is not locked or is software-masked before they reach clustering. It also exports lock status and counters to the slow-control register file.

## Interface
- `DDR`, 0 — 1: aligner runs DDR, 128 S-bits per VFAT per BX; 0: 64.
- `LOCK_CYCLES`, 1024 — consecutive error-free clocks needed to declare lock; legal range 2..65536.
- `ERR_CNT_WIDTH`, 12 — width of each per-VFAT saturating error counter.

Ports:
- `clock`  in  1 — 40 MHz logic clock; the only clock.
- `reset`  in  1 — synchronous, active-high.
- `sbits_i`  in  1536+1536*DDR — aligned S-bits from `trig_alignment`.
  - VFAT v occupies `[v*64*(1+DDR) +: 64*(1+DDR)]`.
- `phase_err`  in  192 — per-pin phase error from the aligner; VFAT v uses pins `[v*8 +: 8]`.
- `vfat_mask`  in  24 — software mask; 1 forces that VFAT's S-bits to zero.
- `cnt_reset`  in  1 — synchronous clear of the counters and sticky flags.
- `sbits_o`  out  1536+1536*DDR — qualified S-bits, registered.
- `vfat_locked`  out  24 — per-VFAT lock state, registered.
- `lost_lock`  out  24 — sticky: VFAT went LOCKED→UNLOCKED since last clear.
- `err_cnt`  out  24*ERR_CNT_WIDTH — VFAT v counter at `[v*W +: W]`.
- `all_locked`  out  1 — registered AND of `vfat_locked | vfat_mask`.

## Operation
- **Per-VFAT error:** `verr[v] = |phase_err[v*8 +: 8]`, evaluated every clock.
- **Per-VFAT FSM:** two states, UNLOCKED and LOCKED, plus a good-cycle counter `good[v]`.
  - `good[v]` width is clog2(LOCK_CYCLES).
  - UNLOCKED, `verr=1`: `good` ← 0.
  - UNLOCKED, `verr=0`, `good` < LOCK_CYCLES-1: `good` increments.
  - UNLOCKED, `verr=0`, `good` = LOCK_CYCLES-1: go to LOCKED, `good` ← 0.
  - LOCKED, `verr=0`: stay in LOCKED.
  - LOCKED, `verr=1`: go to UNLOCKED, `good` ← 0, `lost_lock[v]` ← 1.
- **Lock-next:** `lock_next[v]` is the combinational next state of the FSM.
- **Qualification:** `sbits_o` ← `sbits_i` AND the expanded `(lock_next & ~vfat_mask)`.
  - Consequence: the BX carrying a phase error is itself dropped.
  - The BX that completes the lock window is passed.
- **Error counter:** `err_cnt[v]` increments on every clock with `verr[v]=1`, in either state.
  - Saturates at 2^W-1 with no wrap.
- **`vfat_mask` scope:** affects only `sbits_o` and `all_locked`. The FSM and counters still run for masked VFATs.
- **`cnt_reset`:** clears `err_cnt` and `lost_lock`; does not touch the FSM or `sbits_o`.
  - `cnt_reset` with simultaneous `verr`: the counter becomes 0, not 1 (clear wins).
  - `cnt_reset` with a simultaneous LOCKED→UNLOCKED transition: `lost_lock` becomes 0 (clear wins).
- **`reset`:** all VFATs go to UNLOCKED with `good`=0.
  - `err_cnt`=0, `lost_lock`=0, `vfat_locked`=0, `all_locked`=0, `sbits_o`=0.
  - Reset mid-lock-window discards the partial count; the full LOCK_CYCLES window is needed again.
- **Verification check:** an implementation that uses registered `vfat_locked` instead of `lock_next` for qualification is non-compliant.

## Timing
- **Latency:** `sbits_i` → `sbits_o` is 1 clock.
- **Lock:** with errors clear from edge k onward, `vfat_locked` rises at edge k+LOCK_CYCLES-1. Edge k is the first edge sampling clean input. Count edges inclusive: LOCK_CYCLES clean samples.
- **Lock loss:** `phase_err` asserted before edge k gives:
  - `vfat_locked`=0 after edge k;
  - that VFAT's `sbits_o` slice = 0 after edge k;
  - `lost_lock`=1 after edge k.
- **Mask:** `vfat_mask` is sampled each edge and takes effect on `sbits_o` 1 clock later, with no FSM delay.
- **`all_locked`:** updates at the same edge as `vfat_locked`, computed from `lock_next` and `vfat_mask`.
- **Critical path:** the 8-input OR, FSM next-state, then the AND mask. Everything fits one 40 MHz cycle, so no extra pipelining is required.

## Test plan
- **Clean lock:** `LOCK_CYCLES`=16, reset released, `phase_err`=0, `sbits_i` all-ones.
  - `vfat_locked`=24'hFFFFFF after the 16th clean edge.
  - `sbits_o`=0 before that edge, all-ones on and after it.
- **Single-pin glitch:** with everything locked, pulse `phase_err[13]` for 1 clock.
  - Only `vfat_locked[1]` drops; VFAT1's `sbits_o` slice is 0 for that BX and the next 15.
  - `err_cnt[1]`=1, `lost_lock`=24'h000002, relock 16 edges after the glitch.
- **Mask:** hold `vfat_mask`=24'h800001 while all VFATs are locked.
  - The VFAT0 and VFAT23 slices are 0 one clock later; other slices follow `sbits_i`.
  - `all_locked` stays 1, and masked VFATs' FSMs still count errors.
- **Saturation and clear:** `ERR_CNT_WIDTH`=4, `phase_err[0]` held high for 40 clocks.
  - `err_cnt[0]`=15, held.
  - Asserting `cnt_reset` on a clock that also has an error yields `err_cnt[0]`=0 and `lost_lock[0]`=0.
- **Reset mid-window:** apply reset after 10 of 16 clean cycles.
  - All outputs are 0 the next clock.
  - Lock needs a full 16 further clean edges, with none at the 6th.
- **DDR=1:** repeat the clean-lock and glitch scenarios with the 3072-bit bus.
  - The VFAT1 slice is bits [255:128], zeroed exactly as in the DDR=0 case.
